// File: rtl/dmem_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_wait_ctrl
// Description : Data memory with programmable wait states and a pipeline-freeze
//               handshake. The optional sticky address-error output is enabled
//               by defining DMEM_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_wait_ctrl #(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        ready,
`ifdef DMEM_ERR_EN
    output logic        addr_err,
`endif
    output logic [3:0]  busy_cnt
);

    localparam int         IDX_W       = $clog2(DEPTH);
    localparam logic [3:0] C_WAIT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         busy_cnt_q, busy_cnt_d;
    logic [31:0]        rd_data_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic               ld_q;
    logic               st_q;
    logic               err_q;
    logic [31:0]        mem_q [DEPTH];

    logic               w_req;
    logic [31:0]        w_off;
    logic [IDX_W-1:0]   w_idx;
    logic               w_err;
    logic               w_unused_bits;

    assign w_req = mem_r_en | mem_w_en;
    // Word index is taken from the wrapped byte offset; high bits simply alias.
    assign w_off = addr - BASE_ADDR;
    assign w_idx = w_off[IDX_W+1:2];
    assign w_unused_bits = ^{w_off[31:IDX_W+2], w_off[1:0]};

`ifdef DMEM_ERR_EN
    localparam logic [31:0] C_SPAN = 32'(4 * DEPTH);
    logic addr_err_q;

    assign w_err    = (addr[1:0] != 2'b00) | (addr < BASE_ADDR) | (w_off >= C_SPAN);
    assign addr_err = addr_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_q <= 1'b0;
        end else if (state_q == S_IDLE && w_req && w_err) begin
            addr_err_q <= 1'b1;
        end
    end
`else
    assign w_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        ready      = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = ~w_req;
                if (w_req) begin
                    state_d    = S_BUSY;
                    busy_cnt_d = C_WAIT_INIT;
                end
            end
            S_BUSY: begin
                if (busy_cnt_q != 4'd0) begin
                    busy_cnt_d = busy_cnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_cnt_q <= 4'd0;
            rd_data_q  <= 32'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            ld_q       <= 1'b0;
            st_q       <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            if (state_q == S_IDLE && w_req) begin
                idx_q   <= w_idx;
                wdata_q <= wr_data;
                ld_q    <= mem_r_en;
                st_q    <= mem_w_en;
                err_q   <= w_err;
            end
            // A combined load+store reads the pre-write word at the same edge.
            if (state_q == S_BUSY && busy_cnt_q == 4'd0) begin
                if (st_q && !err_q) begin
                    mem_q[idx_q] <= wdata_q;
                end
                if (ld_q) begin
                    rd_data_q <= err_q ? 32'd0 : mem_q[idx_q];
                end
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign busy_cnt = busy_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_wait_ctrl
// Description : Scoreboard bench for dmem_wait_ctrl with a word-array reference
//               model; covers DMEM_ERR_EN when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_wait_ctrl;

    localparam int          DEPTH = 64;
    localparam int          WAIT  = 3;
    localparam logic [31:0] BASE  = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en;
    logic        w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    logic        ready;
    logic [3:0]  busy_cnt;
`ifdef DMEM_ERR_EN
    logic        addr_err;
`endif

    dmem_wait_ctrl #(
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(WAIT),
        .BASE_ADDR  (BASE)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .mem_r_en(r_en),
        .mem_w_en(w_en),
        .addr    (addr),
        .wr_data (wdata),
        .rd_data (rd_data),
        .ready   (ready),
`ifdef DMEM_ERR_EN
        .addr_err(addr_err),
`endif
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rd;
    logic        model_err;
    logic [31:0] last_rd;
    logic        last_err;
    int          low_cnt;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: tracks each ready-low window and scores the completion cycle.
    always @(negedge clk) begin
        if (rst) begin
            low_cnt  = 0;
            last_rd  = 32'd0;
            last_err = 1'b0;
        end else if (!ready) begin
            if (low_cnt <= WAIT)
                check32("busy_cnt", {28'd0, busy_cnt}, (low_cnt == 0) ? 32'd0 : 32'(WAIT - low_cnt));
            low_cnt++;
        end else if (low_cnt > 0) begin
            check32("ready_low_window", 32'(low_cnt), 32'(WAIT + 1));
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_completion actual=1 expected=0 at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check32("rd_data_done", rd_data, e.rd);
`ifdef DMEM_ERR_EN
                check32("addr_err_done", {31'd0, addr_err}, {31'd0, e.err});
`endif
                last_rd  = e.rd;
                last_err = e.err;
            end
            low_cnt = 0;
        end else begin
            check32("rd_data_hold", rd_data, last_rd);
`ifdef DMEM_ERR_EN
            check32("addr_err_hold", {31'd0, addr_err}, {31'd0, last_err});
`endif
        end
    end

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        model_rd  = 32'd0;
        model_err = 1'b0;
        sb_q.delete();
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        int   idx;
        int   n;
        logic err;
        exp_t e;
        idx = int'(((a - BASE) >> 2) % DEPTH);
        err = 1'b0;
`ifdef DMEM_ERR_EN
        err = (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'(4 * DEPTH));
`endif
        if (rd) model_rd = err ? 32'd0 : model_mem[idx];
        if (wr && !err) model_mem[idx] = d;
        model_err = model_err | err;
        e.rd  = model_rd;
        e.err = model_err;
        @(posedge clk);
        #1;
        r_en  = rd;
        w_en  = wr;
        addr  = a;
        wdata = d;
        sb_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 50);
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL completion_timeout actual=%0d expected=%0d cycles", n, WAIT + 1);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        r_en = 1'b0;
        w_en = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        r_en  = 1'b0;
        w_en  = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check32("reset_ready", {31'd0, ready}, 32'd1);
        check32("reset_rd_data", rd_data, 32'd0);
        check32("reset_busy_cnt", {28'd0, busy_cnt}, 32'd0);

        issue(1'b1, 1'b0, BASE, 32'd0);
        issue(1'b0, 1'b1, BASE + 32'd4, 32'hDEADBEEF);
        issue(1'b1, 1'b0, BASE + 32'd4, 32'd0);
        issue(1'b0, 1'b1, BASE, 32'h11);
        issue(1'b1, 1'b0, BASE, 32'd0);
        issue(1'b0, 1'b1, BASE + 32'd8, 32'h5);
        issue(1'b1, 1'b1, BASE + 32'd8, 32'h9);
        issue(1'b1, 1'b0, BASE + 32'd8, 32'd0);
        idle(2);
        issue(1'b0, 1'b1, BASE + 32'(4 * DEPTH), 32'h77);
        issue(1'b1, 1'b0, BASE, 32'd0);
        idle(1);

        // Reset while a store is still busy: the write must be abandoned.
        @(posedge clk);
        #1;
        w_en  = 1'b1;
        addr  = BASE + 32'd12;
        wdata = 32'h55;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        w_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check32("ready_after_midop_reset", {31'd0, ready}, 32'd1);
        issue(1'b1, 1'b0, BASE + 32'd12, 32'd0);

        issue(1'b0, 1'b1, BASE + 32'd2, 32'hAB);
        issue(1'b1, 1'b0, BASE, 32'd0);
        idle(2);

        for (int k = 0; k < 80; k++) begin
            int          sel;
            int          kind;
            int          gap;
            logic [31:0] a;
            sel  = int'($urandom_range(0, 9));
            kind = int'($urandom_range(0, 5));
            if (sel == 0)
                a = 32'($urandom_range(0, 1023));
            else if (sel == 1)
                a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
            else
                a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1))
                    + ((sel == 2) ? 32'($urandom_range(1, 3)) : 32'd0);
            issue((kind <= 2) || (kind == 5), (kind >= 3), a, $urandom);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) idle(gap);
        end

        idle(3);
        check32("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
